timer_tick_distributor: RTL and testbench
=========================================

// Module: timer_tick_distributor
// PURPOSE
// Sits directly downstream of the interval timer's irq output. Each timeout becomes one
// "tick": the block counts it, fans it out as per-core pending interrupts, and
// acknowledges the timer itself through a small Avalon-MM master that writes the
// timer's status register (address 0). Cores service and clear their own pending bit
// through a 16-bit Avalon-MM slave, so one hardware timer serves every core.
// PARAMETERS
// NUM_CORES   4   number of core interrupt outputs / pending bits (1..16)
// SETTLE_CYC  2   cycles waited after the timer ack write before timer_irq is sampled again (>=1)
// PORTS
// clk            in   1          system clock
// reset          in   1          asynchronous, active-high reset
// timer_irq      in   1          level irq from the interval timer
// tm_address     out  3          master address to the timer; constant 0
// tm_write       out  1          master write strobe (timer status clear)
// tm_writedata   out  16         master write data; constant 0
// tm_waitrequest in   1          master stall; tie 0 if the slave has no waitrequest
// address        in   3          slave register address
// chipselect     in   1          slave select
// read_n         in   1          slave read strobe, active-low
// write_n        in   1          slave write strobe, active-low
// writedata      in   16         slave write data
// readdata       out  16         slave read data, registered; read latency 1
// core_irq       out  NUM_CORES  per-core interrupt = pending & enable
// BEHAVIOUR
// Reset (async) values: fsm=IDLE; tm_write=0; readdata=0; pending=0; enable=0;
//   tick_count=0; shadow=0; overrun=0; core_irq=0.
// Reset mid-transaction drops tm_write immediately; no tick is lost or double-counted
//   once reset is released, because the timer still holds irq until it is acknowledged.
// Register map (rd = read, wr = write; writes take effect on the next clk edge):
//   0 PENDING  rd {0,pending}; wr W1C on bits [NUM_CORES-1:0]
//   1 ENABLE   rd/wr enable mask [NUM_CORES-1:0]; upper bits read 0
//   2 TICK_LO  rd tick_count[15:0], and copies tick_count[31:16] into shadow the same
//              cycle; wr (any data) clears tick_count and shadow
//   3 TICK_HI  rd shadow; wr ignored
//   4 OVERRUN  rd 16-bit saturating overrun count; wr (any data) clears it
//   5 STATUS   rd {15'b0, busy}, where busy = (fsm != IDLE); wr ignored
//   6,7        rd 0; wr ignored
// readdata is registered from the address mux every cycle, matching the timer's style.
// FSM:
//   IDLE:   if timer_irq=1 -> tick event, then go to ACK.
//   ACK:    drive tm_write=1, tm_address=0, tm_writedata=0. Hold until tm_waitrequest=0
//           at a clk edge; then load settle counter = SETTLE_CYC and go to SETTLE.
//   SETTLE: decrement the settle counter; at 0 go to IDLE. timer_irq is ignored while
//           in SETTLE.
// Tick event (a single cycle):
//   - tick_count += 1, 32-bit, wraps 0xFFFFFFFF -> 0.
//   - For each core i with enable[i]=1: set pending[i]. If pending[i] was already 1,
//     overrun += 1 per such core, saturating at 0xFFFF.
//   - Disabled cores get no pending bit and count no overrun.
// Simultaneous events:
//   - Tick set and W1C on the same bit: the set wins (pending stays 1), and the old
//     value decides the overrun.
//   - Tick and a TICK_LO write: the clear wins (count = 0).
//   - Tick and an OVERRUN clear: the clear wins.
//   - TICK_LO read and tick: the low half and the shadow both come from the pre-increment
//     count, giving a coherent 32-bit snapshot.
// ENABLE changes gate core_irq combinationally. Clearing an enable bit does not clear
//   its pending bit.
// core_irq = pending & enable, from registers; no combinational path from the slave inputs.
// TESTING
// 1 Reset, ENABLE=0xF, timer_irq held high until tm_write is accepted -> tm_write high
//   for exactly 1 cycle, PENDING=0xF, TICK_LO=1, core_irq=4'hF, busy returns to 0 after
//   SETTLE_CYC cycles.
// 2 tm_waitrequest=1 for 5 cycles in ACK -> tm_write held for 6 cycles, a single tick
//   counted, tm_address and tm_writedata stay 0.
// 3 ENABLE=0x5; two ticks with no clear -> PENDING=0x5, OVERRUN=2; write PENDING=0x1
//   -> PENDING=0x4, core_irq=4'b0100.
// 4 Preload via 0xFFFF ticks, read TICK_LO/TICK_HI -> 0xFFFF/0x0000; one more tick ->
//   0x0000/0x0001. A TICK_LO read on the same cycle as a tick returns the pre-tick
//   snapshot.
// 5 Tick and W1C of pending[0] on the same cycle -> pending[0] remains 1; assert reset
//   in the middle of ACK -> tm_write=0, core_irq=0, and all registers read 0.

Source files
------------

// File: rtl/timer_tick_distributor_if.sv
// Bus bundle for the tick distributor: Avalon-MM master toward the interval timer
// and the 16-bit Avalon-MM register slave toward the cores.
interface timer_tick_distributor_if;
  // Handshake: a master request (tm_write) holds steady and is accepted at the first
  // clk edge where tm_waitrequest is low; slave reads return readdata one cycle later.
  logic [2:0]  tm_address;
  logic        tm_write;
  logic [15:0] tm_writedata;
  logic        tm_waitrequest;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  // slave: the distributor's view; master: the view of the host/timer side around it
  modport slave (
    output tm_address, tm_write, tm_writedata, readdata,
    input  tm_waitrequest, address, chipselect, read_n, write_n, writedata
  );
  modport master (
    input  tm_address, tm_write, tm_writedata, readdata,
    output tm_waitrequest, address, chipselect, read_n, write_n, writedata
  );
endinterface

// File: rtl/timer_tick_distributor.sv
// Turns each interval-timer timeout into one counted tick, fans it out as per-core
// pending interrupts and acknowledges the timer with a status-clear write.
module timer_tick_distributor #(
  parameter int NUM_CORES  = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     timer_irq,
  timer_tick_distributor_if.slave  bus,
  output logic [NUM_CORES-1:0]     core_irq,
  output logic [1:0]               dbg_state
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [NUM_CORES-1:0]   pending_q, pending_d;
  logic [NUM_CORES-1:0]   enable_q, enable_d;
  logic [31:0]            tick_count_q, tick_count_d;
  logic [15:0]            shadow_q, shadow_d;
  logic [15:0]            overrun_q, overrun_d;
  logic [15:0]            readdata_q, readdata_d;

  logic                   tick;
  logic                   wr_en;
  logic                   rd_en;
  logic                   tm_write;
  logic [NUM_CORES-1:0]   w1c_mask;
  logic [NUM_CORES-1:0]   set_mask;
  logic [4:0]             ovr_inc;
  logic [16:0]            ovr_sum;
  logic [15:0]            pend_rd;
  logic [15:0]            en_rd;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic; timer_irq is deliberately ignored in SETTLE so the timer's
  // irq has time to fall after the status-clear write.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        if (timer_irq) state_d = ACK;
      end
      ACK: begin
        if (!bus.tm_waitrequest) begin
          state_d  = SETTLE;
          settle_d = SW'(SETTLE_CYC);
        end
      end
      SETTLE: begin
        settle_d = settle_q - SW'(1);
        if (settle_q <= SW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    tm_write  = (state_q == ACK);
    tick      = (state_q == IDLE) && timer_irq;
    dbg_state = state_q;
  end

  assign bus.tm_write     = tm_write;
  assign bus.tm_address   = 3'd0;
  assign bus.tm_writedata = 16'd0;

  always_comb begin
    wr_en    = bus.chipselect && !bus.write_n;
    rd_en    = bus.chipselect && !bus.read_n;
    w1c_mask = (wr_en && bus.address == 3'd0) ? bus.writedata[NUM_CORES-1:0] : '0;
    set_mask = tick ? enable_q : '0;
    // Set wins over W1C; the old pending value decides the overrun.
    pending_d = (pending_q & ~w1c_mask) | set_mask;

    ovr_inc = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      ovr_inc = ovr_inc + {4'b0, set_mask[i] & pending_q[i]};
    end
    ovr_sum = {1'b0, overrun_q} + {12'b0, ovr_inc};
    if (wr_en && bus.address == 3'd4) overrun_d = '0;
    else if (ovr_sum[16])              overrun_d = 16'hFFFF;
    else                               overrun_d = ovr_sum[15:0];

    enable_d = (wr_en && bus.address == 3'd1) ? bus.writedata[NUM_CORES-1:0] : enable_q;

    if (wr_en && bus.address == 3'd2) tick_count_d = '0;
    else if (tick)                     tick_count_d = tick_count_q + 32'd1;
    else                               tick_count_d = tick_count_q;

    // Shadow captures the pre-increment high half so TICK_LO/TICK_HI form one snapshot.
    if (wr_en && bus.address == 3'd2)      shadow_d = '0;
    else if (rd_en && bus.address == 3'd2) shadow_d = tick_count_q[31:16];
    else                                   shadow_d = shadow_q;
  end

  always_comb begin
    pend_rd                  = '0;
    pend_rd[NUM_CORES-1:0]   = pending_q;
    en_rd                    = '0;
    en_rd[NUM_CORES-1:0]     = enable_q;
    case (bus.address)
      3'd0:    readdata_d = pend_rd;
      3'd1:    readdata_d = en_rd;
      3'd2:    readdata_d = tick_count_q[15:0];
      3'd3:    readdata_d = shadow_q;
      3'd4:    readdata_d = overrun_q;
      3'd5:    readdata_d = {15'b0, state_q != IDLE};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= '0;
      enable_q     <= '0;
      tick_count_q <= '0;
      shadow_q     <= '0;
      overrun_q    <= '0;
      readdata_q   <= '0;
    end else begin
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      tick_count_q <= tick_count_d;
      shadow_q     <= shadow_d;
      overrun_q    <= overrun_d;
      readdata_q   <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign core_irq     = pending_q & enable_q;

endmodule

// File: tb/tb_timer_tick_distributor.sv
// Directed bench for timer_tick_distributor: a small timer model acknowledges ticks,
// register reads go through an expected-value queue.
module tb_timer_tick_distributor;

  logic       clk;
  logic       reset;
  logic       timer_irq;
  logic [3:0] core_irq;
  logic [1:0] dbg_state;

  timer_tick_distributor_if bus ();

  timer_tick_distributor #(.NUM_CORES(4), .SETTLE_CYC(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .timer_irq (timer_irq),
    .bus       (bus),
    .core_irq  (core_irq),
    .dbg_state (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    bus.writedata  = 16'd0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    exp_q.push_back(exp);
    @(negedge clk);
    bus_idle();
    check(tag, {16'b0, bus.readdata}, {16'b0, exp_q.pop_front()});
  endtask

  // One timeout: irq raised, held until the ack write is accepted after ws stalls.
  // op 1 = slave write (a,d) in the tick cycle, op 2 = slave read (a) expecting exp.
  task automatic do_tick(input int ws, input int op, input logic [2:0] a,
                         input logic [15:0] d, input logic [15:0] exp,
                         input string tag, output int wcyc);
    bit done;
    for (int i = 0; i < 20 && dbg_state != 2'd0; i++) @(negedge clk);
    check({tag, " idle before"}, {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    timer_irq = 1'b1;
    bus.tm_waitrequest = 1'b0;
    if (op == 1) begin
      bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    end else if (op == 2) begin
      bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
      exp_q.push_back(exp);
    end
    wcyc = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus_idle();
        if (op == 2) check({tag, " snapshot"}, {16'b0, bus.readdata}, {16'b0, exp_q.pop_front()});
      end
      if (bus.tm_write) begin
        wcyc++;
        bus.tm_waitrequest = (wcyc <= ws);
        if (ws > 0) begin
          check({tag, " tm_address"}, {29'b0, bus.tm_address}, 32'd0);
          check({tag, " tm_writedata"}, {16'b0, bus.tm_writedata}, 32'd0);
        end
      end else if (wcyc > 0) begin
        done = 1'b1;
      end
    end
    timer_irq = 1'b0;
    bus.tm_waitrequest = 1'b0;
    check({tag, " ack accepted"}, {31'b0, done}, 32'd1);
  endtask

  int wc;
  int n;

  initial begin
    reset = 1'b1;
    timer_irq = 1'b0;
    bus.tm_waitrequest = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    check("reset tm_write", {31'b0, bus.tm_write}, 32'd0);
    check("reset core_irq", {28'b0, core_irq}, 32'd0);
    check("reset readdata", {16'b0, bus.readdata}, 32'd0);
    check("reset state", {30'b0, dbg_state}, 32'd0);
    reset = 1'b0;

    // 1: single tick fan-out
    wr(3'd1, 16'h000F);
    do_tick(0, 0, 3'd0, 16'd0, 16'd0, "t1", wc);
    check("t1 tm_write cycles", wc, 32'd1);
    n = 0;
    for (int i = 0; i < 20 && dbg_state != 2'd0; i++) begin
      @(negedge clk);
      n++;
    end
    check("t1 busy cycles", n, 32'd2);
    rd(3'd0, 16'h000F, "t1 PENDING");
    rd(3'd2, 16'h0001, "t1 TICK_LO");
    check("t1 core_irq", {28'b0, core_irq}, 32'hF);
    rd(3'd5, 16'h0000, "t1 STATUS");

    // 2: stalled ack
    do_tick(5, 0, 3'd0, 16'd0, 16'd0, "t2", wc);
    check("t2 tm_write cycles", wc, 32'd6);
    rd(3'd2, 16'h0002, "t2 TICK_LO");
    rd(3'd4, 16'h0004, "t2 OVERRUN");

    // 3: partial enable, overrun, W1C
    wr(3'd1, 16'hFFF5);
    rd(3'd1, 16'h0005, "t3 ENABLE");
    wr(3'd0, 16'h000F);
    wr(3'd4, 16'h1234);
    rd(3'd4, 16'h0000, "t3 OVERRUN cleared");
    check("t3 core_irq cleared", {28'b0, core_irq}, 32'h0);
    do_tick(0, 0, 3'd0, 16'd0, 16'd0, "t3a", wc);
    do_tick(0, 0, 3'd0, 16'd0, 16'd0, "t3b", wc);
    rd(3'd0, 16'h0005, "t3 PENDING");
    rd(3'd4, 16'h0002, "t3 OVERRUN");
    check("t3 core_irq", {28'b0, core_irq}, 32'h5);
    wr(3'd0, 16'h0001);
    rd(3'd0, 16'h0004, "t3 PENDING after W1C");
    check("t3 core_irq after W1C", {28'b0, core_irq}, 32'h4);

    // 5a: simultaneous events
    wr(3'd1, 16'h000F);
    wr(3'd0, 16'h000F);
    wr(3'd4, 16'h0000);
    do_tick(0, 1, 3'd0, 16'h0001, 16'd0, "t5 tick+W1C", wc);
    rd(3'd0, 16'h000F, "t5 PENDING set wins");
    rd(3'd4, 16'h0000, "t5 OVERRUN old pending");
    do_tick(0, 1, 3'd2, 16'hABCD, 16'd0, "t5 tick+TICKclr", wc);
    rd(3'd2, 16'h0000, "t5 TICK_LO clear wins");
    rd(3'd3, 16'h0000, "t5 TICK_HI cleared");
    rd(3'd4, 16'h0004, "t5 OVERRUN +4");
    do_tick(0, 1, 3'd4, 16'h5555, 16'd0, "t5 tick+OVRclr", wc);
    rd(3'd4, 16'h0000, "t5 OVERRUN clear wins");
    rd(3'd2, 16'h0001, "t5 TICK_LO");

    // 4: 32-bit count rollover of the low half and snapshot coherence
    @(negedge clk);
    force dut.tick_count_q = 32'h0000_FFFE;
    @(negedge clk);
    release dut.tick_count_q;
    do_tick(0, 0, 3'd0, 16'd0, 16'd0, "t4a", wc);
    rd(3'd2, 16'hFFFF, "t4 TICK_LO ffff");
    rd(3'd3, 16'h0000, "t4 TICK_HI 0");
    do_tick(0, 0, 3'd0, 16'd0, 16'd0, "t4b", wc);
    rd(3'd2, 16'h0000, "t4 TICK_LO wrap");
    rd(3'd3, 16'h0001, "t4 TICK_HI 1");
    @(negedge clk);
    force dut.tick_count_q = 32'h0001_FFFF;
    @(negedge clk);
    release dut.tick_count_q;
    do_tick(0, 2, 3'd2, 16'd0, 16'hFFFF, "t4 read+tick", wc);
    rd(3'd3, 16'h0001, "t4 TICK_HI pre-tick");
    rd(3'd2, 16'h0000, "t4 TICK_LO post");
    rd(3'd3, 16'h0002, "t4 TICK_HI post");

    // overrun saturation
    @(negedge clk);
    force dut.overrun_q = 16'hFFFE;
    @(negedge clk);
    release dut.overrun_q;
    do_tick(0, 0, 3'd0, 16'd0, 16'd0, "sat", wc);
    rd(3'd4, 16'hFFFF, "OVERRUN saturates");

    // 5b: reset in the middle of ACK
    for (int i = 0; i < 20 && dbg_state != 2'd0; i++) @(negedge clk);
    timer_irq = 1'b1;
    bus.tm_waitrequest = 1'b1;
    for (int i = 0; i < 10 && !bus.tm_write; i++) @(negedge clk);
    check("t5 in ack", {31'b0, bus.tm_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5 reset tm_write", {31'b0, bus.tm_write}, 32'd0);
    check("t5 reset core_irq", {28'b0, core_irq}, 32'd0);
    check("t5 reset state", {30'b0, dbg_state}, 32'd0);
    timer_irq = 1'b0;
    bus.tm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, "t5 reg after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
